hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core: the next generation of the E-stage HILO block. It takes a one-cycle start pulse from the E stage and holds busy for a configurable number of cycles. It then commits results to HI/LO. Compared with the current block it adds:
- configurable width and latency
- accumulate modes (madd/msub)
- defined divide-by-zero and overflow results
- a cancel input for the exception/flush path

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (legal range 1..63)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..63)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle request; sampled only when busy=0 and cancel=0
- op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11..15 treated as none
- a  input  WIDTH  rs operand (E-stage forwarded value)
- b  input  WIDTH  rt operand (E-stage forwarded value)
- cancel  input  1  aborts any in-flight operation; HI/LO are not updated
- busy  output  1  registered; high while an operation is in flight
- hi  output  WIDTH  registered HI contents
- lo  output  WIDTH  registered LO contents

## Operation
- Reset: busy=0, hi=0, lo=0, counter=0, latched result=0. Reset takes effect mid-operation immediately, with no commit.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, counter counting down)
- IDLE→RUN on start & !cancel when op is one of {1,2,3,4,7..10}:
  - result pair {hi_n, lo_n} is computed from a, b and the current hi/lo at the sampling edge
  - result pair is latched
  - counter loads MULT_CYCLES or DIV_CYCLES per op
- RUN: the counter decrements each cycle. When counter=1, at that edge:
  - hi/lo take the latched pair
  - state returns to IDLE
- mthi/mtlo on start in IDLE: hi (resp. lo) takes a at that edge; busy stays 0.
- op none/undefined with start: no effect.
- Arithmetic (2·WIDTH-bit product P):
  - mult: signed P = a·b; multu: unsigned P = a·b; result {hi,lo} = P.
  - madd/maddu: {hi,lo} + P, wrapping modulo 2^(2·WIDTH).
  - msub/msubu: {hi,lo} − P, wrapping modulo 2^(2·WIDTH).
  - div signed: lo = quotient truncated toward zero; hi = remainder with the sign of a.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (div or divu): hi = a, lo = all ones.
  - Signed overflow (a = −2^(WIDTH−1), b = −1): lo = a, hi = 0.
- Start while busy=1: ignored. The controller stalls D on busy|start for md-class ops.
- Cancel:
  - In RUN: state returns to IDLE next edge, busy=0, hi/lo keep pre-op values.
  - In IDLE: blocks any same-cycle start, including mthi/mtlo.
  - Cancel and the commit edge (counter=1) in the same cycle: cancel wins, no commit.
- Operands and hi/lo used for accumulation are captured at start. Later changes to a/b have no effect.

## Timing
- start sampled at edge T:
  - busy=1 from T through the cycle before edge T+N, where N = MULT_CYCLES or DIV_CYCLES
  - at edge T+N, hi/lo update and busy falls in the same edge
- busy is high for exactly N cycles; a dependent mfhi/mflo reads the new value in the cycle after edge T+N.
- mthi/mtlo: value visible on hi/lo one cycle after the start edge; zero busy cycles.
- Back-to-back: a new start is accepted on the same edge busy falls only if busy was 0 in the sampled cycle. Minimum issue interval is therefore N+1 cycles.
- N=1: busy high for one cycle; commit at T+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-op: mult a=3, b=5, assert reset at cycle 2 → busy=0, hi=lo=0 immediately; no later commit.
- mult, default latency: a=32'hFFFF_FFFF (−1), b=2.
  - busy high exactly 5 cycles.
  - Then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE.
  - multu with the same operands → hi=1, lo=32'hFFFF_FFFE.
- div with negative dividend: a=−7, b=2 → lo=−3 (32'hFFFF_FFFD), hi=−1 after 10 busy cycles.
- div edge cases:
  - a=32'h8000_0000, b=32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
  - divu a=9, b=0 → hi=9, lo=32'hFFFF_FFFF.
- Accumulate sequence: mthi 0, then mtlo 10, then madd a=4, b=5 → lo=30, hi=0. Then msub a=8, b=4 → lo=32'hFFFF_FFFE, hi=32'hFFFF_FFFF.
- Cancel: mtlo 7, then mult a=2, b=3, then cancel asserted at the commit cycle → lo=7, busy=0. A start held during busy is ignored: no second op is observed.

Source files
------------

// File: rtl/hilo_mdu_if.sv
// E-stage to multiply/divide unit request bus plus the registered HI/LO
// and busy status coming back.
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, cancel, input busy, hi, lo);
    modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/hilo_mdu.sv
// Multiply/divide unit with HI/LO registers: the result is computed when the
// request is sampled, then held back and committed after a fixed latency.
module hilo_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    hilo_mdu_if.slave  bus
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [W2-1:0]    res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e              op_in;
    logic [W2-1:0]    acc, prod_s, prod_u, res_n;
    logic [WIDTH-1:0] mag_a, mag_b, quo_m, rem_m, quo_u, rem_u, quo_s, rem_s;

    assign op_in = op_e'(bus.op);

    // Datapath: the most-negative / -1 case falls out of the magnitude
    // divide as quotient == a, remainder == 0, so it needs no special mux.
    always_comb begin
        acc    = {hi_q, lo_q};
        prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        mag_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
        mag_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
        quo_m  = '0;
        rem_m  = '0;
        quo_u  = '0;
        rem_u  = '0;
        if (bus.b != '0) begin
            quo_m = mag_a / mag_b;
            rem_m = mag_a % mag_b;
            quo_u = bus.a / bus.b;
            rem_u = bus.a % bus.b;
        end
        quo_s = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) ? -quo_m : quo_m;
        rem_s = bus.a[WIDTH-1] ? -rem_m : rem_m;
        res_n = '0;
        case (op_in)
            OP_MULT:  res_n = prod_s;
            OP_MULTU: res_n = prod_u;
            OP_MADD:  res_n = acc + prod_s;
            OP_MADDU: res_n = acc + prod_u;
            OP_MSUB:  res_n = acc - prod_s;
            OP_MSUBU: res_n = acc - prod_u;
            OP_DIV:   res_n = (bus.b == '0) ? {bus.a, {WIDTH{1'b1}}} : {rem_s, quo_s};
            OP_DIVU:  res_n = (bus.b == '0) ? {bus.a, {WIDTH{1'b1}}} : {rem_u, quo_u};
            default:  res_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_d = S_RUN;
                            cnt_d   = MULT_N;
                            res_d   = res_n;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_RUN;
                            cnt_d   = DIV_N;
                            res_d   = res_n;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Cancel outranks the commit edge.
                if (bus.cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 6'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    {hi_d, lo_d} = res_q;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Randomised check of hilo_mdu against a plain-arithmetic HI/LO model,
// including latency, cancel and the divide corner cases.
module tb_hilo_mdu;
    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    hilo_mdu_if #(.WIDTH(32)) bus ();

    hilo_mdu #(.WIDTH(32), .MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_md(input logic [3:0] o);
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
    endfunction

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] av,
                                          input logic [31:0] bv, input logic [63:0] acc);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = av;
        sb = bv;
        sp = longint'(sa) * longint'(sb);
        up = 64'(av) * 64'(bv);
        case (o)
            4'd1:  return sp;
            4'd2:  return up;
            4'd7:  return acc + sp;
            4'd8:  return acc + up;
            4'd9:  return acc - sp;
            4'd10: return acc - up;
            4'd3: begin
                if (bv == 0) return {av, 32'hFFFF_FFFF};
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, av};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (bv == 0) return {av, 32'hFFFF_FFFF};
                return {av % bv, av / bv};
            end
            default: return acc;
        endcase
    endfunction

    // Issue one request; cancel_at >= 0 raises cancel in that busy cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input int cancel_at, input bit cancel_idle, input bit hold);
        logic [63:0] pair;
        int          exp_n, busy_n;
        bit          commit;
        pair   = model(o, av, bv, {m_hi, m_lo});
        commit = !cancel_idle && is_md(o) && cancel_at < 0;
        if (cancel_idle || !is_md(o)) exp_n = 0;
        else if (cancel_at >= 0)      exp_n = cancel_at + 1;
        else                          exp_n = (o == 4'd3 || o == 4'd4) ? N_DIV : N_MULT;
        bus.start  = 1'b1;
        bus.op     = o;
        bus.a      = av;
        bus.b      = bv;
        bus.cancel = cancel_idle;
        step();
        bus.cancel = 1'b0;
        bus.start  = hold;
        bus.op     = hold ? 4'd5 : 4'd0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        busy_n = 0;
        while (bus.busy && busy_n < 80) begin
            bus.cancel = (busy_n == cancel_at);
            step();
            bus.cancel = 1'b0;
            busy_n++;
        end
        bus.start = 1'b0;
        chk("busy_cycles", 64'(busy_n), 64'(exp_n));
        if (commit) {m_hi, m_lo} = pair;
        else if (!cancel_idle && o == 4'd5) m_hi = av;
        else if (!cancel_idle && o == 4'd6) m_lo = av;
        chk("hi", 64'(bus.hi), 64'(m_hi));
        chk("lo", 64'(bus.lo), 64'(m_lo));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = '0;
        bus.a      = '0;
        bus.b      = '0;
        m_hi = '0;
        m_lo = '0;
        step();
        step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        step();

        // Reset in the middle of a multiply discards it.
        issue(4'd5, 32'h55, 32'h0, -1, 0, 0);
        bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'd3; bus.b = 32'd5;
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        step();
        reset = 1'b0;
        repeat (8) step();
        chk("midrst_late_hi", 64'(bus.hi), 64'd0);
        chk("midrst_late_lo", 64'(bus.lo), 64'd0);
        chk("midrst_late_busy", 64'(bus.busy), 64'd0);
        m_hi = '0;
        m_lo = '0;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, -1, 0, 0);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, -1, 0, 0);
        chk("multu_hi", 64'(bus.hi), 64'd1);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, -1, 0, 0);
        chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 0);
        chk("divovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("divovf_hi", 64'(bus.hi), 64'd0);
        issue(4'd4, 32'd9, 32'd0, -1, 0, 0);
        chk("div0_hi", 64'(bus.hi), 64'd9);
        chk("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);

        issue(4'd5, 32'd0, 32'd0, -1, 0, 0);
        issue(4'd6, 32'd10, 32'd0, -1, 0, 0);
        issue(4'd7, 32'd4, 32'd5, -1, 0, 0);
        chk("madd_lo", 64'(bus.lo), 64'd30);
        issue(4'd9, 32'd8, 32'd4, -1, 0, 0);
        chk("msub_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        chk("msub_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        // Cancel on the commit cycle with a start held through busy.
        issue(4'd6, 32'd7, 32'd0, -1, 0, 0);
        issue(4'd1, 32'd2, 32'd3, N_MULT - 1, 0, 1);
        chk("cancel_lo", 64'(bus.lo), 64'd7);
        step();
        chk("cancel_busy", 64'(bus.busy), 64'd0);
        issue(4'd6, 32'd99, 32'd0, -1, 1, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] o;
            int         ca;
            int         n;
            o  = 4'($urandom_range(0, 15));
            n  = (o == 4'd3 || o == 4'd4) ? N_DIV : N_MULT;
            ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            issue(o, rnd_val(), rnd_val(), ca, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
